// File: rtl/decode_resource_ctrl.sv
// Decode-side resource bookkeeping: ROB head/tail tags and occupancy, ALU and branch
// reservation-station occupancy, and the stall flags decode uses before allocating.
module decode_resource_ctrl #(
  parameter int ROB       = 2,
  parameter int ALU_DEPTH = 4,
  parameter int BR_DEPTH  = 2,
  parameter int CW        = 3
) (
  input  logic          clk,
  input  logic          globalReset_n,
  input  logic          robReq,
  input  logic          stationRequest,
  input  logic [1:0]    RSstation,
  input  logic          validCommit,
  input  logic          flush,
  input  logic          aluIssue,
  input  logic          branchIssue,
  output logic [ROB:0]  robAllocation,
  output logic [ROB:0]  commitROB,
  output logic [CW:0]   robCount,
  output logic          fullRob,
  output logic          ALUFull,
  output logic          branchFull,
  output logic          allocErr
);

  localparam int ROB_DEPTH = 2 ** (ROB + 1);
  localparam int CNT_W     = CW + 1;
  localparam int ALU_W     = $clog2(ALU_DEPTH + 1);
  localparam int BR_W      = $clog2(BR_DEPTH + 1);

  localparam logic [CNT_W-1:0] ROB_MAX = CNT_W'(ROB_DEPTH);
  localparam logic [ALU_W-1:0] ALU_MAX = ALU_W'(ALU_DEPTH);
  localparam logic [BR_W-1:0]  BR_MAX  = BR_W'(BR_DEPTH);

  logic [ROB:0]       tail;
  logic [ROB:0]       head;
  logic [CNT_W-1:0]   rob_cnt;
  logic [ALU_W-1:0]   alu_cnt;
  logic [BR_W-1:0]    br_cnt;
  logic               err;

  logic alu_req;
  logic br_req;
  logic commit_ok;
  logic rob_alloc_ok;
  logic alu_issue_ok;
  logic alu_alloc_ok;
  logic br_issue_ok;
  logic br_alloc_ok;
  logic err_set;

  // A request at full occupancy is still accepted when a release frees a slot in the same cycle.
  always_comb begin
    alu_req      = stationRequest & (RSstation == 2'b00);
    br_req       = stationRequest & (RSstation == 2'b01);
    commit_ok    = validCommit & (rob_cnt != '0);
    rob_alloc_ok = robReq & ((rob_cnt != ROB_MAX) | commit_ok);
    alu_issue_ok = aluIssue & (alu_cnt != '0);
    alu_alloc_ok = alu_req & ((alu_cnt != ALU_MAX) | alu_issue_ok);
    br_issue_ok  = branchIssue & (br_cnt != '0);
    br_alloc_ok  = br_req & ((br_cnt != BR_MAX) | br_issue_ok);
    err_set      = (robReq & ~rob_alloc_ok) | (alu_req & ~alu_alloc_ok) |
                   (br_req & ~br_alloc_ok);
  end

  // ROB pointers and occupancy; pointer width gives the modulo wrap for free.
  always_ff @(posedge clk or negedge globalReset_n) begin
    if (!globalReset_n) begin
      tail    <= '0;
      head    <= '0;
      rob_cnt <= '0;
    end else if (flush) begin
      tail    <= '0;
      head    <= '0;
      rob_cnt <= '0;
    end else begin
      if (rob_alloc_ok) tail <= tail + 1'b1;
      if (commit_ok)    head <= head + 1'b1;
      unique case ({rob_alloc_ok, commit_ok})
        2'b10:   rob_cnt <= rob_cnt + 1'b1;
        2'b01:   rob_cnt <= rob_cnt - 1'b1;
        default: rob_cnt <= rob_cnt;
      endcase
    end
  end

  // Reservation-station occupancy
  always_ff @(posedge clk or negedge globalReset_n) begin
    if (!globalReset_n) begin
      alu_cnt <= '0;
      br_cnt  <= '0;
    end else if (flush) begin
      alu_cnt <= '0;
      br_cnt  <= '0;
    end else begin
      unique case ({alu_alloc_ok, alu_issue_ok})
        2'b10:   alu_cnt <= alu_cnt + 1'b1;
        2'b01:   alu_cnt <= alu_cnt - 1'b1;
        default: alu_cnt <= alu_cnt;
      endcase
      unique case ({br_alloc_ok, br_issue_ok})
        2'b10:   br_cnt <= br_cnt + 1'b1;
        2'b01:   br_cnt <= br_cnt - 1'b1;
        default: br_cnt <= br_cnt;
      endcase
    end
  end

  // Sticky overflow indicator survives flush; requests discarded by flush never raise it.
  always_ff @(posedge clk or negedge globalReset_n) begin
    if (!globalReset_n) begin
      err <= 1'b0;
    end else if (!flush && err_set) begin
      err <= 1'b1;
    end
  end

  always_comb begin
    robAllocation = tail;
    commitROB     = head;
    robCount      = rob_cnt;
    allocErr      = err;
    fullRob       = ({1'b0, rob_cnt} + {{CNT_W{1'b0}}, robReq}) >= {1'b0, ROB_MAX};
    ALUFull       = ({1'b0, alu_cnt} + {{ALU_W{1'b0}}, alu_req}) >= {1'b0, ALU_MAX};
    branchFull    = ({1'b0, br_cnt} + {{BR_W{1'b0}}, br_req}) >= {1'b0, BR_MAX};
  end

endmodule

// File: tb/tb_decode_resource_ctrl.sv
// Directed scenarios plus randomized traffic for decode_resource_ctrl, checked against an
// occupancy model built from allocation/release totals.
module tb_decode_resource_ctrl;

  logic       clk;
  logic       globalReset_n;
  logic       robReq;
  logic       stationRequest;
  logic [1:0] RSstation;
  logic       validCommit;
  logic       flush;
  logic       aluIssue;
  logic       branchIssue;
  logic [2:0] robAllocation;
  logic [2:0] commitROB;
  logic [3:0] robCount;
  logic       fullRob;
  logic       ALUFull;
  logic       branchFull;
  logic       allocErr;

  int checks   = 0;
  int failures = 0;

  // Reference model: totals of accepted allocations/commits give pointers and occupancy.
  int allocs, commits, alu_n, br_n;
  bit err_m;

  decode_resource_ctrl #(.ROB(2), .ALU_DEPTH(4), .BR_DEPTH(2), .CW(3)) dut (
    .clk(clk), .globalReset_n(globalReset_n), .robReq(robReq),
    .stationRequest(stationRequest), .RSstation(RSstation), .validCommit(validCommit),
    .flush(flush), .aluIssue(aluIssue), .branchIssue(branchIssue),
    .robAllocation(robAllocation), .commitROB(commitROB), .robCount(robCount),
    .fullRob(fullRob), .ALUFull(ALUFull), .branchFull(branchFull), .allocErr(allocErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    allocs = 0; commits = 0; alu_n = 0; br_n = 0; err_m = 1'b0;
  endtask

  function automatic int live();
    return allocs - commits;
  endfunction

  task automatic check_model(input string tag);
    int a_req, b_req;
    a_req = (stationRequest && RSstation == 2'b00) ? 1 : 0;
    b_req = (stationRequest && RSstation == 2'b01) ? 1 : 0;
    chk({tag, "_tail"},  int'(robAllocation), allocs % 8);
    chk({tag, "_head"},  int'(commitROB), commits % 8);
    chk({tag, "_count"}, int'(robCount), live());
    chk({tag, "_fullRob"}, int'(fullRob), (live() + int'(robReq) >= 8) ? 1 : 0);
    chk({tag, "_ALUFull"}, int'(ALUFull), (alu_n + a_req >= 4) ? 1 : 0);
    chk({tag, "_brFull"},  int'(branchFull), (br_n + b_req >= 2) ? 1 : 0);
    chk({tag, "_err"},   int'(allocErr), int'(err_m));
  endtask

  task automatic model_step();
    bit c, a, ai, aa, bi, ba, areq, breq;
    if (flush) begin
      allocs = 0; commits = 0; alu_n = 0; br_n = 0;
      return;
    end
    areq = stationRequest && RSstation == 2'b00;
    breq = stationRequest && RSstation == 2'b01;
    c  = validCommit && live() > 0;
    a  = robReq && (live() < 8 || c);
    ai = aluIssue && alu_n > 0;
    aa = areq && (alu_n < 4 || ai);
    bi = branchIssue && br_n > 0;
    ba = breq && (br_n < 2 || bi);
    if ((robReq && !a) || (areq && !aa) || (breq && !ba)) err_m = 1'b1;
    allocs  += int'(a);
    commits += int'(c);
    alu_n   += int'(aa) - int'(ai);
    br_n    += int'(ba) - int'(bi);
    if (commits >= 8) begin
      allocs  -= 8;
      commits -= 8;
    end
  endtask

  task automatic drive(input logic rr, input logic sr, input logic [1:0] st,
                       input logic vc, input logic fl, input logic ai, input logic bi);
    robReq = rr; stationRequest = sr; RSstation = st;
    validCommit = vc; flush = fl; aluIssue = ai; branchIssue = bi;
  endtask

  // One cycle: inputs already driven; compare at the falling edge, then advance.
  task automatic cyc(input string tag);
    @(negedge clk);
    check_model(tag);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic run(input string tag, input logic rr, input logic sr, input logic [1:0] st,
                     input logic vc, input logic fl, input logic ai, input logic bi);
    drive(rr, sr, st, vc, fl, ai, bi);
    cyc(tag);
  endtask

  task automatic rand_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
      cyc("rnd");
    end
  endtask

  initial begin
    globalReset_n = 1'b0;
    drive(0, 0, 2'b00, 0, 0, 0, 0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tail", int'(robAllocation), 0);
    chk("rst_head", int'(commitROB), 0);
    chk("rst_count", int'(robCount), 0);
    chk("rst_flags", int'({fullRob, ALUFull, branchFull, allocErr}), 0);
    @(negedge clk);
    globalReset_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: eight back-to-back allocations fill the ROB.
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 2'b11, 0, 0, 0, 0);
      @(negedge clk);
      chk("t1_tag", int'(robAllocation), i);
      chk("t1_full", int'(fullRob), (i == 7) ? 1 : 0);
      check_model("t1");
      @(posedge clk);
      model_step();
      #1;
    end
    drive(0, 0, 2'b11, 0, 0, 0, 0);
    #1;
    chk("t1_count", int'(robCount), 8);
    chk("t1_fullidle", int'(fullRob), 1);

    // 2: full ROB, allocate and commit together.
    run("t2", 1, 0, 2'b11, 1, 0, 0, 0);
    drive(0, 0, 2'b11, 0, 0, 0, 0);
    #1;
    chk("t2_count", int'(robCount), 8);
    chk("t2_tail", int'(robAllocation), 1);
    chk("t2_head", int'(commitROB), 1);
    chk("t2_err", int'(allocErr), 0);

    // 3: fill the ALU station, then issue one.
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 2'b00, 1, 0, 0, 0);
      @(negedge clk);
      chk("t3_alufull_req", int'(ALUFull), (i == 3) ? 1 : 0);
      check_model("t3");
      @(posedge clk);
      model_step();
      #1;
    end
    run("t3_issue", 0, 0, 2'b00, 0, 0, 1, 0);
    drive(0, 0, 2'b00, 0, 0, 0, 0);
    #1;
    chk("t3_alufull_after", int'(ALUFull), 0);

    // 4: five live ROB entries, two branch RS entries, flush with a same-cycle robReq.
    run("t4_clr", 0, 0, 2'b11, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++)
      run("t4_fill", 1, (i < 2), 2'b01, 0, 0, 0, 0);
    drive(0, 0, 2'b11, 0, 0, 0, 0);
    #1;
    chk("t4_pre_count", int'(robCount), 5);
    chk("t4_pre_brfull", int'(branchFull), 1);
    run("t4_flush", 1, 1, 2'b00, 1, 1, 0, 0);
    drive(0, 0, 2'b11, 0, 0, 0, 0);
    #1;
    chk("t4_count", int'(robCount), 0);
    chk("t4_ptrs", int'({robAllocation, commitROB}), 0);
    chk("t4_flags", int'({fullRob, ALUFull, branchFull}), 0);

    // 5: overflow request sets the sticky error, which survives flush.
    for (int i = 0; i < 8; i++) run("t5_fill", 1, 0, 2'b11, 0, 0, 0, 0);
    run("t5_over", 1, 0, 2'b11, 0, 0, 0, 0);
    drive(0, 0, 2'b11, 0, 0, 0, 0);
    #1;
    chk("t5_err", int'(allocErr), 1);
    chk("t5_tail", int'(robAllocation), 0);
    chk("t5_count", int'(robCount), 8);
    run("t5_flush", 0, 0, 2'b11, 0, 1, 0, 0);
    chk("t5_err_sticky", int'(allocErr), 1);

    rand_cycles(400);

    // 6: asynchronous reset between edges.
    run("t6_clr", 0, 0, 2'b11, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) run("t6_fill", 1, 1, 2'b00, 0, 0, 0, 0);
    drive(0, 0, 2'b11, 0, 0, 0, 0);
    #2;
    chk("t6_pre_count", int'(robCount), 3);
    globalReset_n = 1'b0;
    #1;
    chk("t6_tail", int'(robAllocation), 0);
    chk("t6_count", int'(robCount), 0);
    chk("t6_flags", int'({fullRob, ALUFull, branchFull, allocErr}), 0);
    model_reset();
    @(negedge clk);
    globalReset_n = 1'b1;
    @(posedge clk);
    #1;

    rand_cycles(150);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
